pe_cfg_loader: RTL and testbench

Upstream configuration sequencer for the PE array. It accepts a valid/ready stream of (PE id, instruction) words from the host/config memory. It clears the PEs and steers each word into the addressed PE's configuration buffer via per-PE init strobes. It then drives the array-wide run strobe for a programmed number of cycles and signals completion.

---
 rtl/pe_cfg_loader.sv | 156 +++++++++++++++
 tb/tb_pe_cfg_loader.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/pe_cfg_loader.sv
// Configuration sequencer for the PE array: clears the PEs, steers (PE id, instruction)
// words into per-PE config buffers, then drives the array-wide run strobe for a bounded length.
module pe_cfg_loader #(
   parameter int unsigned NUM_PE = 16,
   parameter int unsigned INST_W = 48,
   parameter int unsigned DEPTH  = 16,
   parameter int unsigned ID_W   = $clog2(NUM_PE),
   parameter int unsigned LEN_W  = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load_req,
   input  logic              cfg_valid,
   output logic              cfg_ready,
   input  logic [ID_W-1:0]   cfg_pe_id,
   input  logic [INST_W-1:0] cfg_inst,
   input  logic              cfg_last,
   input  logic              start,
   input  logic [LEN_W-1:0]  run_len,
   output logic              pe_rst,
   output logic [NUM_PE-1:0] pe_init,
   output logic [INST_W-1:0] pe_inst,
   output logic              pe_run,
   output logic              busy,
   output logic              done,
   output logic              err_overflow,
   output logic              err_bad_id
);

   typedef enum logic [2:0] {
      S_IDLE, S_CLEAR, S_LOAD, S_READY, S_RUN, S_DONE
   } state_t;

   state_t              state_q, state_d;
   logic [LEN_W-1:0]    run_cnt_q, run_cnt_d;
   logic [LEN_W-1:0]    cnt_q [NUM_PE];
   logic [LEN_W-1:0]    sel_cnt;
   logic                id_ok;
   logic                cnt_clr;
   logic [NUM_PE-1:0]   pe_init_d;
   logic [INST_W-1:0]   pe_inst_d;
   logic                err_ovf_d, err_bad_d;
   logic                pe_rst_d, pe_run_d, busy_d, done_d;

   assign cfg_ready = (state_q == S_LOAD);

   // Next-state, run counter and next values of the registered outputs
   always_comb begin
      state_d   = state_q;
      run_cnt_d = run_cnt_q;
      pe_init_d = '0;
      pe_inst_d = pe_inst;
      err_ovf_d = err_overflow;
      err_bad_d = err_bad_id;
      cnt_clr   = 1'b0;
      sel_cnt   = '0;
      id_ok     = 32'(cfg_pe_id) < NUM_PE;

      for (int unsigned i = 0; i < NUM_PE; i++) begin
         if (cfg_pe_id == ID_W'(i)) sel_cnt = cnt_q[i];
      end

      case (state_q)
         S_IDLE: begin
            if (load_req) state_d = S_CLEAR;
         end
         S_CLEAR: begin
            cnt_clr   = 1'b1;
            err_ovf_d = 1'b0;
            err_bad_d = 1'b0;
            state_d   = S_LOAD;
         end
         S_LOAD: begin
            if (cfg_valid) begin
               if (!id_ok) begin
                  err_bad_d = 1'b1;
               end else if (sel_cnt == LEN_W'(DEPTH)) begin
                  err_ovf_d = 1'b1;
               end else begin
                  pe_inst_d = cfg_inst;
                  for (int unsigned i = 0; i < NUM_PE; i++) begin
                     pe_init_d[i] = (cfg_pe_id == ID_W'(i));
                  end
               end
               if (cfg_last) state_d = S_READY;
            end
         end
         S_READY: begin
            // start has priority over a simultaneous reload request
            if (start) begin
               if (run_len == '0) begin
                  state_d = S_DONE;
               end else begin
                  state_d   = S_RUN;
                  run_cnt_d = (run_len > LEN_W'(DEPTH)) ? LEN_W'(DEPTH) : run_len;
               end
            end else if (load_req) begin
               state_d = S_CLEAR;
            end
         end
         S_RUN: begin
            run_cnt_d = run_cnt_q - LEN_W'(1);
            if (run_cnt_q == LEN_W'(1)) state_d = S_DONE;
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      pe_rst_d = (state_d == S_CLEAR);
      pe_run_d = (state_d == S_RUN);
      done_d   = (state_d == S_DONE);
      busy_d   = (state_d != S_IDLE) && (state_d != S_READY);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         run_cnt_q    <= '0;
         pe_rst       <= 1'b0;
         pe_init      <= '0;
         pe_inst      <= '0;
         pe_run       <= 1'b0;
         busy         <= 1'b0;
         done         <= 1'b0;
         err_overflow <= 1'b0;
         err_bad_id   <= 1'b0;
      end else begin
         state_q      <= state_d;
         run_cnt_q    <= run_cnt_d;
         pe_rst       <= pe_rst_d;
         pe_init      <= pe_init_d;
         pe_inst      <= pe_inst_d;
         pe_run       <= pe_run_d;
         busy         <= busy_d;
         done         <= done_d;
         err_overflow <= err_ovf_d;
         err_bad_id   <= err_bad_d;
      end
   end

   // Per-PE fill counters mirror each PE buffer occupancy; they saturate by dropping words
   always_ff @(posedge clk) begin
      for (int unsigned i = 0; i < NUM_PE; i++) begin
         if (rst || cnt_clr) begin
            cnt_q[i] <= '0;
         end else if (pe_init_d[i]) begin
            cnt_q[i] <= cnt_q[i] + LEN_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_pe_cfg_loader.sv
// Scoreboard bench for pe_cfg_loader; NUM_PE=12 so an out-of-range PE id is representable.
module tb_pe_cfg_loader;
   localparam int unsigned NPE = 12;
   localparam int unsigned IW  = 48;
   localparam int unsigned DEP = 16;
   localparam int unsigned IDW = $clog2(NPE);
   localparam int unsigned LW  = $clog2(DEP + 1);

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic           load_req = 1'b0;
   logic           cfg_valid = 1'b0;
   logic           cfg_ready;
   logic [IDW-1:0] cfg_pe_id = '0;
   logic [IW-1:0]  cfg_inst = '0;
   logic           cfg_last = 1'b0;
   logic           start = 1'b0;
   logic [LW-1:0]  run_len = '0;
   logic           pe_rst;
   logic [NPE-1:0] pe_init;
   logic [IW-1:0]  pe_inst;
   logic           pe_run;
   logic           busy;
   logic           done;
   logic           err_overflow;
   logic           err_bad_id;

   int n_pass  = 0;
   int n_total = 0;

   logic [NPE-1:0] sb_init [$];
   logic [IW-1:0]  sb_inst [$];
   int             mcnt [NPE];
   logic           m_ovf, m_bad;
   logic [IW-1:0]  last_inst;

   pe_cfg_loader #(.NUM_PE(NPE), .INST_W(IW), .DEPTH(DEP), .ID_W(IDW), .LEN_W(LW)) dut (
      .clk(clk), .rst(rst), .load_req(load_req), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
      .cfg_pe_id(cfg_pe_id), .cfg_inst(cfg_inst), .cfg_last(cfg_last), .start(start),
      .run_len(run_len), .pe_rst(pe_rst), .pe_init(pe_init), .pe_inst(pe_inst), .pe_run(pe_run),
      .busy(busy), .done(done), .err_overflow(err_overflow), .err_bad_id(err_bad_id)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      last_inst = '0;
      n_total++; if (pe_rst !== 1'b0) $display("FAIL reset_pe_rst: got %b exp 0", pe_rst); else n_pass++;
      n_total++; if (pe_init !== '0) $display("FAIL reset_pe_init: got %h exp 0", pe_init); else n_pass++;
      n_total++; if (pe_inst !== '0) $display("FAIL reset_pe_inst: got %h exp 0", pe_inst); else n_pass++;
      n_total++; if (pe_run !== 1'b0 || done !== 1'b0) $display("FAIL reset_run_done: got %b%b exp 00", pe_run, done); else n_pass++;
      n_total++; if (busy !== 1'b0 || cfg_ready !== 1'b0) $display("FAIL reset_busy_ready: got %b%b exp 00", busy, cfg_ready); else n_pass++;
      n_total++; if (err_overflow !== 1'b0 || err_bad_id !== 1'b0) $display("FAIL reset_err: got %b%b exp 00", err_overflow, err_bad_id); else n_pass++;
   endtask

   task automatic test_idle_start_ignored();
      start = 1'b1;
      run_len = LW'(5);
      tick();
      start = 1'b0;
      tick();
      n_total++; if (pe_run !== 1'b0) $display("FAIL idle_start_run: got %b exp 0", pe_run); else n_pass++;
      n_total++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL idle_start_busy_done: got %b%b exp 00", busy, done); else n_pass++;
   endtask

   task automatic start_load();
      load_req = 1'b1;
      tick();
      load_req = 1'b0;
      n_total++; if (pe_rst !== 1'b1) $display("FAIL clear_pe_rst: got %b exp 1", pe_rst); else n_pass++;
      n_total++; if (busy !== 1'b1 || cfg_ready !== 1'b0) $display("FAIL clear_busy_ready: got %b%b exp 10", busy, cfg_ready); else n_pass++;
      for (int i = 0; i < NPE; i++) mcnt[i] = 0;
      m_ovf = 1'b0;
      m_bad = 1'b0;
      tick();
      n_total++; if (pe_rst !== 1'b0) $display("FAIL load_pe_rst_len: got %b exp 0", pe_rst); else n_pass++;
      n_total++; if (cfg_ready !== 1'b1 || busy !== 1'b1) $display("FAIL load_ready_busy: got %b%b exp 11", cfg_ready, busy); else n_pass++;
      n_total++; if (err_overflow !== 1'b0 || err_bad_id !== 1'b0) $display("FAIL clear_err: got %b%b exp 00", err_overflow, err_bad_id); else n_pass++;
   endtask

   task automatic send_word(input int id, input logic [IW-1:0] inst, input logic last);
      logic [NPE-1:0] ei;
      logic [IW-1:0]  eq;
      n_total++; if (cfg_ready !== 1'b1) $display("FAIL word_ready id=%0d: got %b exp 1", id, cfg_ready); else n_pass++;
      cfg_valid = 1'b1;
      cfg_pe_id = IDW'(id);
      cfg_inst  = inst;
      cfg_last  = last;
      if (id >= int'(NPE)) begin
         m_bad = 1'b1;
      end else if (mcnt[id] >= int'(DEP)) begin
         m_ovf = 1'b1;
      end else begin
         ei = '0;
         ei[id] = 1'b1;
         sb_init.push_back(ei);
         sb_inst.push_back(inst);
         mcnt[id]++;
         last_inst = inst;
      end
      tick();
      cfg_valid = 1'b0;
      cfg_last  = 1'b0;
      if (sb_init.size() > 0) begin
         ei = sb_init.pop_front();
         eq = sb_inst.pop_front();
         n_total++; if (pe_init !== ei || pe_inst !== eq) $display("FAIL word_out id=%0d: got init=%h inst=%h exp init=%h inst=%h", id, pe_init, pe_inst, ei, eq); else n_pass++;
      end else begin
         n_total++; if (pe_init !== '0) $display("FAIL word_drop id=%0d: got init=%h exp 0", id, pe_init); else n_pass++;
      end
      n_total++; if (err_overflow !== m_ovf || err_bad_id !== m_bad) $display("FAIL word_err id=%0d: got ovf=%b bad=%b exp ovf=%b bad=%b", id, err_overflow, err_bad_id, m_ovf, m_bad); else n_pass++;
   endtask

   task automatic test_three_words();
      start_load();
      send_word(2, 48'hA, 1'b0);
      send_word(2, 48'hB, 1'b0);
      send_word(2, 48'hC, 1'b1);
      n_total++; if (busy !== 1'b0 || cfg_ready !== 1'b0) $display("FAIL ready_after_last: got busy=%b ready=%b exp 00", busy, cfg_ready); else n_pass++;
      tick();
      n_total++; if (pe_init !== '0 || pe_inst !== 48'hC) $display("FAIL ready_hold: got init=%h inst=%h exp 0 / c", pe_init, pe_inst); else n_pass++;
   endtask

   task automatic do_run(input int len, input int exp_cycles, input bit poke_load);
      int  runs = 0;
      int  done_at = -1;
      int  clears = 0;
      start   = 1'b1;
      run_len = LW'(len);
      tick();
      start = 1'b0;
      for (int c = 0; c < 64 && done_at < 0; c++) begin
         if (done === 1'b1) begin
            done_at = c;
            n_total++; if (pe_run !== 1'b0) $display("FAIL run_at_done len=%0d: got %b exp 0", len, pe_run); else n_pass++;
         end else begin
            if (pe_run === 1'b1) runs++;
            if (pe_rst === 1'b1) clears++;
            if (poke_load && c == 1) load_req = 1'b1;
            tick();
            load_req = 1'b0;
         end
      end
      n_total++; if (done_at !== exp_cycles) $display("FAIL run_done_time len=%0d: got %0d exp %0d", len, done_at, exp_cycles); else n_pass++;
      n_total++; if (runs !== exp_cycles) $display("FAIL run_cycles len=%0d: got %0d exp %0d", len, runs, exp_cycles); else n_pass++;
      n_total++; if (clears !== 0) $display("FAIL run_load_ignored len=%0d: got %0d exp 0", len, clears); else n_pass++;
      tick();
      n_total++; if (done !== 1'b0 || busy !== 1'b0 || pe_run !== 1'b0) $display("FAIL run_end_idle len=%0d: got done=%b busy=%b run=%b exp 000", len, done, busy, pe_run); else n_pass++;
   endtask

   task automatic test_overflow();
      start_load();
      for (int i = 0; i < 16; i++) send_word(0, 48'h1000 | IW'(i), 1'b0);
      tick();
      n_total++; if (pe_init !== '0 || pe_inst !== last_inst || cfg_ready !== 1'b1) $display("FAIL load_gap: got init=%h inst=%h ready=%b exp 0 %h 1", pe_init, pe_inst, cfg_ready, last_inst); else n_pass++;
      send_word(0, 48'h1FFF, 1'b1);
      n_total++; if (err_overflow !== 1'b1) $display("FAIL overflow_flag: got %b exp 1", err_overflow); else n_pass++;
   endtask

   task automatic test_bad_id();
      start_load();
      send_word(13, 48'hBAD, 1'b0);
      send_word(3, 48'h33, 1'b1);
      n_total++; if (err_bad_id !== 1'b1 || err_overflow !== 1'b0) $display("FAIL bad_id_flags: got bad=%b ovf=%b exp 1 0", err_bad_id, err_overflow); else n_pass++;
   endtask

   task automatic test_run_clamp();
      start_load();
      send_word(5, 48'h55, 1'b1);
      do_run(20, 16, 1'b0);
   endtask

   task automatic test_rst_mid_run();
      int dones = 0;
      start_load();
      send_word(1, 48'h11, 1'b1);
      start   = 1'b1;
      run_len = LW'(10);
      tick();
      start = 1'b0;
      tick();
      tick();
      n_total++; if (pe_run !== 1'b1) $display("FAIL rst_run_third: got %b exp 1", pe_run); else n_pass++;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      last_inst = '0;
      n_total++; if (pe_run !== 1'b0 || busy !== 1'b0 || done !== 1'b0) $display("FAIL rst_mid_run: got run=%b busy=%b done=%b exp 000", pe_run, busy, done); else n_pass++;
      n_total++; if (pe_inst !== '0 || pe_init !== '0) $display("FAIL rst_mid_run_inst: got %h %h exp 0 0", pe_inst, pe_init); else n_pass++;
      for (int c = 0; c < 20; c++) begin
         if (done === 1'b1 || pe_run === 1'b1) dones++;
         tick();
      end
      n_total++; if (dones !== 0) $display("FAIL rst_no_done: got %0d exp 0", dones); else n_pass++;
      start   = 1'b1;
      run_len = LW'(4);
      tick();
      start = 1'b0;
      tick();
      n_total++; if (pe_run !== 1'b0 || busy !== 1'b0) $display("FAIL rst_then_start: got run=%b busy=%b exp 00", pe_run, busy); else n_pass++;
   endtask

   initial begin
      test_reset();
      test_idle_start_ignored();
      test_three_words();
      do_run(5, 5, 1'b1);
      test_overflow();
      test_bad_id();
      do_run(0, 0, 1'b0);
      test_run_clamp();
      test_rst_mid_run();
      n_total++; if (sb_init.size() != 0) $display("FAIL sb_empty: got %0d exp 0", sb_init.size()); else n_pass++;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
